// File: rtl/arbiter_wrr.sv
// -----------------------------------------------------------------------------
// arbiter_wrr
// Weighted round-robin arbiter with a per-requester credit burst. It shares one
// DW-bit valid/ready output stream between BUS_NUM requesters. Each requester
// owns the input side for up to weight[i] beats. The weights can be reprogrammed
// at run time.
//
// Ports
//   clk, rst      clock and synchronous active-high reset
//   cfg_we        weight write strobe
//   cfg_idx       requester index for the weight write (out-of-range ignored)
//   cfg_weight    weight value; 0 masks the requester
//   valid_in      per-requester valid
//   data_in       requester i occupies [DW*i+DW-1 -: DW]
//   ready_out     per-requester ready (only the current owner can see it)
//   valid_out     registered output valid
//   data_out      registered output data
//   grant_id      index of the requester that supplied data_out
//   ready_in      sink ready
//
// Optional build macro ARB_WRR_PKT_LOCK_EN
//   Adds last_in (per requester) and last_out (registered with data_out).
//   A grant is then held until the owner's beat flagged last_in is taken, and
//   a withdrawn valid does not release it.
// -----------------------------------------------------------------------------
module arbiter_wrr #(
  parameter int BUS_NUM = 8,
  parameter int DW      = 8,
  parameter int WW      = 4,
  localparam int IW     = $clog2(BUS_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [IW-1:0]         cfg_idx,
  input  logic [WW-1:0]         cfg_weight,
  input  logic [BUS_NUM-1:0]    valid_in,
  input  logic [BUS_NUM*DW-1:0] data_in,
`ifdef ARB_WRR_PKT_LOCK_EN
  input  logic [BUS_NUM-1:0]    last_in,
  output logic                  last_out,
`endif
  output logic [BUS_NUM-1:0]    ready_out,
  output logic                  valid_out,
  output logic [DW-1:0]         data_out,
  output logic [IW-1:0]         grant_id,
  input  logic                  ready_in
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [WW-1:0] credit, credit_nxt;
  logic [WW-1:0] weight [BUS_NUM];

  logic          accept;
  logic          in_hs;
  logic          release_grant;
  logic          hit_found;
  logic [IW-1:0] hit_idx;
  logic [IW-1:0] scan_idx;
  int            scan_pos;
  logic [DW-1:0] owner_data;

  // Round-robin search starting at ptr. The first valid requester with a
  // nonzero weight wins, so a masked requester is skipped even when it is the
  // only one asking.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    scan_pos  = 0;
    scan_idx  = '0;
    for (int k = 0; k < BUS_NUM; k++) begin
      scan_pos = (int'(ptr) + k) % BUS_NUM;
      scan_idx = IW'(scan_pos);
      if (!hit_found && valid_in[scan_idx] && (weight[scan_idx] != '0)) begin
        hit_found = 1'b1;
        hit_idx   = scan_idx;
      end
    end
  end

  // Select the owner's data lane with constant slices.
  always_comb begin
    owner_data = '0;
    for (int i = 0; i < BUS_NUM; i++) begin
      if (owner == IW'(i)) begin
        owner_data = data_in[i*DW +: DW];
      end
    end
  end

  // Next-state logic and owner ready. The output register accepts a new beat
  // when it is empty or being drained this cycle. On release, ptr moves past
  // the owner. The following IDLE cycle is the single bubble between owners.
  always_comb begin
    accept        = !valid_out || ready_in;
    in_hs         = (state == GRANT) && valid_in[owner] && accept;
    ready_out     = '0;
    state_nxt     = state;
    ptr_nxt       = ptr;
    owner_nxt     = owner;
    credit_nxt    = credit;
    release_grant = 1'b0;

    case (state)
      IDLE: begin
        if (hit_found) begin
          owner_nxt  = hit_idx;
          credit_nxt = weight[hit_idx];
          state_nxt  = GRANT;
        end
      end
      GRANT: begin
        ready_out[owner] = valid_in[owner] && accept;
`ifdef ARB_WRR_PKT_LOCK_EN
        // Packet mode: credit only counts down, and only the last beat releases.
        if (in_hs) begin
          if (credit != '0) begin
            credit_nxt = credit - WW'(1);
          end
          release_grant = last_in[owner];
        end
`else
        if (in_hs) begin
          credit_nxt    = credit - WW'(1);
          release_grant = (credit <= WW'(1));
        end else if (!valid_in[owner]) begin
          release_grant = 1'b1;
        end
`endif
        if (release_grant) begin
          state_nxt = IDLE;
          ptr_nxt   = (owner == IW'(BUS_NUM - 1)) ? '0 : owner + IW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      owner  <= '0;
      credit <= '0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      owner  <= owner_nxt;
      credit <= credit_nxt;
    end
  end

  // Weight table. A write to the current owner changes only its next burst
  // length, because the running credit was copied at grant time.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUS_NUM; i++) begin
        weight[i] <= WW'(1);
      end
    end else if (cfg_we && (int'(cfg_idx) < BUS_NUM)) begin
      weight[cfg_idx] <= cfg_weight;
    end
  end

  // Single-entry output register. A refill and a sink pop can happen in the
  // same cycle. The contents hold while the sink stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      grant_id  <= '0;
`ifdef ARB_WRR_PKT_LOCK_EN
      last_out  <= 1'b0;
`endif
    end else if (in_hs) begin
      valid_out <= 1'b1;
      data_out  <= owner_data;
      grant_id  <= owner;
`ifdef ARB_WRR_PKT_LOCK_EN
      last_out  <= last_in[owner];
`endif
    end else if (ready_in) begin
      valid_out <= 1'b0;
    end
  end

endmodule
